// File: rtl/onewire_pkg.sv
// Shared constants for the 1-wire multi-device scan sequencer:
// transceiver op codes, DS18B20 command bytes, CRC polynomial and FSM states.
package onewire_pkg;

    // Transceiver operation codes
    localparam logic [1:0] OP_RST = 2'b00;  // reset / presence detect
    localparam logic [1:0] OP_WR  = 2'b01;  // write one byte
    localparam logic [1:0] OP_RD  = 2'b10;  // read one byte

    // ROM and function commands
    localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T = 8'h44;
    localparam logic [7:0] CMD_MATCH_ROM = 8'h55;
    localparam logic [7:0] CMD_READ_SP   = 8'hBE;

    // Dallas CRC-8 (x^8+x^5+x^4+1), bit-reflected form
    localparam logic [7:0] CRC_POLY_R = 8'h8C;

    // Byte counts on the wire
    localparam logic [3:0] ROM_LAST = 4'd7;  // 8 ROM bytes, index 0..7
    localparam logic [3:0] SP_LAST  = 4'd8;  // 9 scratchpad bytes, index 0..8

    typedef enum logic [3:0] {
        S_IDLE,
        S_CV_RST,
        S_CV_SKIP,
        S_CV_CONV,
        S_CV_WAIT,
        S_DV_RST,
        S_DV_MATCH,
        S_DV_ROM,
        S_DV_RDCMD,
        S_DV_READ,
        S_DV_CHECK,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/onewire_crc8.sv
// Byte-serial Dallas CRC-8: one byte per cycle when byte_valid is high,
// bits consumed LSB first, register cleared to 0x00 by clear.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       fb;

    // Unrolled 8-step shift of the reflected CRC over the incoming byte
    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb    = crc_d[0] ^ byte_in[i[2:0]];
            crc_d = crc_d >> 1;
            if (fb) begin
                crc_d = crc_d ^ CRC_POLY_R;
            end
        end
    end

    // CRC register: clear has priority over a byte update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (byte_valid) begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/onewire_multi_scan.sv
// Scan sequencer for NUM_DEV DS18B20 sensors on one 1-wire bus: broadcast
// Convert-T, then per device Match-ROM + Read-Scratchpad, CRC check, and a
// per-device temperature/valid/present table readable through rd_sel.
module onewire_multi_scan
    import onewire_pkg::*;
#(
    parameter int unsigned NUM_DEV      = 8,
    parameter int unsigned DEV_W        = 3,
    parameter int unsigned CONV_CYCLES  = 750000,
    parameter int unsigned AUTO_RESTART = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [DEV_W-1:0]   rom_idx,
    input  logic [63:0]        rom_code,
    output logic               cmd_valid,
    output logic [1:0]         cmd_op,
    output logic [7:0]         cmd_data,
    input  logic               cmd_ready,
    input  logic               rsp_valid,
    input  logic [7:0]         rsp_data,
    input  logic               rsp_presence,
    input  logic [DEV_W-1:0]   rd_sel,
    output logic [15:0]        rd_temp,
    output logic               rd_valid,
    output logic [NUM_DEV-1:0] present,
    output logic               busy,
    output logic               scan_done,
    output logic               crc_err,
    output logic               no_bus
);

    state_e             state_q, state_d;
    logic               wait_q, wait_d;      // command transferred, awaiting rsp_valid
    logic [3:0]         cnt_q, cnt_d;        // ROM / scratchpad byte index
    logic [31:0]        conv_q, conv_d;      // conversion wait counter
    logic [DEV_W-1:0]   idx_q, idx_d;        // current device
    logic [7:0]         b0_q, b0_d;          // scratchpad byte 0 (temp LSB)
    logic [7:0]         b1_q, b1_d;          // scratchpad byte 1 (temp MSB)
    logic               all_ff_q, all_ff_d;  // every byte so far was 0xFF
    logic               no_bus_q, no_bus_d;
    logic               run_q;

    logic [NUM_DEV-1:0][15:0] temp_q;
    logic [NUM_DEV-1:0]       valid_q;
    logic [NUM_DEV-1:0]       present_q;

    logic       rsp_hit;
    logic       start;
    logic       crc_clear;
    logic       crc_en;
    logic [7:0] crc_out;
    logic       tbl_clr_all;
    logic       tbl_absent;
    logic       tbl_accept;
    logic       tbl_reject;

    // A response only counts while a command is outstanding
    assign rsp_hit = wait_q & rsp_valid;
    assign start   = (AUTO_RESTART != 0) ? run : (run & ~run_q);

    onewire_crc8 u_crc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (crc_clear),
        .byte_valid (crc_en),
        .byte_in    (rsp_data),
        .crc_out    (crc_out)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= 1'b0;
            cnt_q    <= '0;
            conv_q   <= '0;
            idx_q    <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            all_ff_q <= 1'b0;
            no_bus_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
            conv_q   <= conv_d;
            idx_q    <= idx_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            all_ff_q <= all_ff_d;
            no_bus_q <= no_bus_d;
            run_q    <= run;
        end
    end

    // Next-state, command issue and table-update decode
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        conv_d      = conv_q;
        idx_d       = idx_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        all_ff_d    = all_ff_q;
        no_bus_d    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = OP_RST;
        cmd_data    = '0;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;
        crc_err     = 1'b0;
        tbl_clr_all = 1'b0;
        tbl_absent  = 1'b0;
        tbl_accept  = 1'b0;
        tbl_reject  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CV_RST;
                end
            end
            S_CV_RST: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_RST;
                if (rsp_hit) begin
                    wait_d = 1'b0;
                    if (rsp_presence) begin
                        state_d = S_CV_SKIP;
                    end else begin
                        no_bus_d    = 1'b1;
                        tbl_clr_all = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_CV_SKIP: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_WR;
                cmd_data  = CMD_SKIP_ROM;
                if (rsp_hit) begin
                    wait_d  = 1'b0;
                    state_d = S_CV_CONV;
                end
            end
            S_CV_CONV: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_WR;
                cmd_data  = CMD_CONVERT_T;
                if (rsp_hit) begin
                    wait_d  = 1'b0;
                    conv_d  = '0;
                    state_d = S_CV_WAIT;
                end
            end
            S_CV_WAIT: begin
                if (conv_q == CONV_CYCLES - 1) begin
                    idx_d   = '0;
                    state_d = S_DV_RST;
                end else begin
                    conv_d = conv_q + 32'd1;
                end
            end
            S_DV_RST: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_RST;
                if (rsp_hit) begin
                    wait_d = 1'b0;
                    if (rsp_presence) begin
                        state_d = S_DV_MATCH;
                    end else begin
                        tbl_absent = 1'b1;
                        state_d    = S_NEXT;
                    end
                end
            end
            S_DV_MATCH: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_WR;
                cmd_data  = CMD_MATCH_ROM;
                if (rsp_hit) begin
                    wait_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DV_ROM;
                end
            end
            S_DV_ROM: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_WR;
                cmd_data  = rom_code[{cnt_q[2:0], 3'b000} +: 8];
                if (rsp_hit) begin
                    wait_d = 1'b0;
                    if (cnt_q == ROM_LAST) begin
                        state_d = S_DV_RDCMD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DV_RDCMD: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_WR;
                cmd_data  = CMD_READ_SP;
                if (rsp_hit) begin
                    wait_d    = 1'b0;
                    cnt_d     = '0;
                    all_ff_d  = 1'b1;
                    crc_clear = 1'b1;
                    state_d   = S_DV_READ;
                end
            end
            S_DV_READ: begin
                cmd_valid = ~wait_q;
                cmd_op    = OP_RD;
                if (rsp_hit) begin
                    wait_d   = 1'b0;
                    crc_en   = 1'b1;
                    all_ff_d = all_ff_q & (rsp_data == 8'hFF);
                    if (cnt_q == 4'd0) begin
                        b0_d = rsp_data;
                    end
                    if (cnt_q == 4'd1) begin
                        b1_d = rsp_data;
                    end
                    if (cnt_q == SP_LAST) begin
                        state_d = S_DV_CHECK;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DV_CHECK: begin
                if ((crc_out == 8'h00) && !all_ff_q) begin
                    tbl_accept = 1'b1;
                end else begin
                    tbl_reject = 1'b1;
                    crc_err    = 1'b1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (32'(idx_q) == NUM_DEV - 1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + DEV_W'(1);
                    state_d = S_DV_RST;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_valid && cmd_ready) begin
            wait_d = 1'b1;
        end
    end

    // Per-device result table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_q    <= '0;
            valid_q   <= '0;
            present_q <= '0;
        end else if (tbl_clr_all) begin
            valid_q   <= '0;
            present_q <= '0;
        end else if (tbl_absent) begin
            valid_q[idx_q]   <= 1'b0;
            present_q[idx_q] <= 1'b0;
        end else if (tbl_accept) begin
            temp_q[idx_q]    <= {b1_q, b0_q};
            valid_q[idx_q]   <= 1'b1;
            present_q[idx_q] <= 1'b1;
        end else if (tbl_reject) begin
            valid_q[idx_q]   <= 1'b0;
            present_q[idx_q] <= 1'b1;
        end
    end

    // Combinational table read port
    always_comb begin
        rd_temp  = '0;
        rd_valid = 1'b0;
        if (32'(rd_sel) < NUM_DEV) begin
            rd_temp  = temp_q[rd_sel];
            rd_valid = valid_q[rd_sel];
        end
    end

    assign rom_idx   = idx_q;
    assign present   = present_q;
    assign busy      = (state_q != S_IDLE);
    assign scan_done = (state_q == S_DONE);
    assign no_bus    = no_bus_q;

endmodule

// File: tb/tb_onewire_multi_scan.sv
// Directed bench for onewire_multi_scan with two devices: a behavioural
// transceiver/sensor model answers commands, each task checks one scenario.
module tb_onewire_multi_scan;
    import onewire_pkg::*;

    localparam int unsigned NUM_DEV = 2;
    localparam int unsigned DEV_W   = 1;
    localparam int unsigned CONV    = 10;
    localparam logic [63:0] ROM0    = 64'hA1B2C3D4E5F60728;
    localparam logic [63:0] ROM1    = 64'h1122334455667728;

    logic               clk;
    logic               rst_n;
    logic               run;
    logic [DEV_W-1:0]   rom_idx;
    logic [63:0]        rom_code;
    logic               cmd_valid;
    logic [1:0]         cmd_op;
    logic [7:0]         cmd_data;
    logic               cmd_ready;
    logic               rsp_valid;
    logic [7:0]         rsp_data;
    logic               rsp_presence;
    logic [DEV_W-1:0]   rd_sel;
    logic [15:0]        rd_temp;
    logic               rd_valid;
    logic [NUM_DEV-1:0] present;
    logic               busy;
    logic               scan_done;
    logic               crc_err;
    logic               no_bus;

    onewire_multi_scan #(
        .NUM_DEV      (NUM_DEV),
        .DEV_W        (DEV_W),
        .CONV_CYCLES  (CONV),
        .AUTO_RESTART (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .rom_idx      (rom_idx),
        .rom_code     (rom_code),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .rd_sel       (rd_sel),
        .rd_temp      (rd_temp),
        .rd_valid     (rd_valid),
        .present      (present),
        .busy         (busy),
        .scan_done    (scan_done),
        .crc_err      (crc_err),
        .no_bus       (no_bus)
    );

    // ROM store: combinational lookup by requested index
    assign rom_code = (rom_idx == 1'b1) ? ROM1 : ROM0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus model state
    int          cyc, rst_cnt, wcnt, rd_cnt, rsp_cd, n_rsp;
    int          n_done, n_crc, n_nobus;
    logic [7:0]  pend_data;
    logic        pend_pres;
    logic [1:0]  log_op[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    logic        bus_pres;
    logic [1:0]  dev_pres;
    logic [7:0]  sp [2][9];
    logic [7:0]  good_sp [9];
    bit          stall_armed, stall_bad;
    int          stall_left, stall_cycles;
    logic [7:0]  stall_data;

    // Transceiver + sensors: accept commands, answer two cycles later
    initial begin
        cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; rsp_presence = 1'b0;
        cyc = 0; rsp_cd = 0; n_rsp = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            cyc++;
            rsp_valid = 1'b0;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    rsp_valid    = 1'b1;
                    rsp_data     = pend_data;
                    rsp_presence = pend_pres;
                    n_rsp++;
                end
            end
            if (scan_done === 1'b1) n_done++;
            if (crc_err === 1'b1)   n_crc++;
            if (no_bus === 1'b1)    n_nobus++;
            if (stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_cycles++;
                if (cmd_valid !== 1'b1 || cmd_data !== stall_data) stall_bad = 1'b1;
                stall_left--;
            end else if (stall_armed && cmd_valid === 1'b1 && cmd_op == OP_WR
                         && rst_cnt >= 2 && wcnt == 4) begin
                stall_armed  = 1'b0;
                cmd_ready    = 1'b0;
                stall_data   = cmd_data;
                stall_left   = 4;
                stall_cycles = 1;
            end else begin
                cmd_ready = 1'b1;
            end
            if (cmd_valid === 1'b1 && cmd_ready) begin
                log_op.push_back(cmd_op);
                log_data.push_back(cmd_data);
                log_cyc.push_back(cyc);
                pend_data = 8'h00;
                pend_pres = 1'b0;
                case (cmd_op)
                    OP_RST: begin
                        pend_pres = (rst_cnt == 0) ? bus_pres : dev_pres[rst_cnt-1];
                        rst_cnt++;
                        wcnt   = 0;
                        rd_cnt = 0;
                    end
                    OP_WR: wcnt++;
                    default: begin
                        if (rst_cnt >= 2 && rst_cnt <= 3 && rd_cnt < 9)
                            pend_data = sp[rst_cnt-2][rd_cnt];
                        else
                            pend_data = 8'hFF;
                        rd_cnt++;
                    end
                endcase
                rsp_cd = 2;
            end
        end
    end

    task automatic model_clear();
        rst_cnt = 0; wcnt = 0; rd_cnt = 0;
        log_op.delete(); log_data.delete(); log_cyc.delete();
        n_done = 0; n_crc = 0; n_nobus = 0;
        stall_cycles = 0; stall_bad = 1'b0;
    endtask

    task automatic load_good();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 9; k++) sp[d][k] = good_sp[k];
    endtask

    task automatic run_scan(input bit hold, output bit ok);
        model_clear();
        run = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        if (!hold) run = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (n_done > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        n_tests++;
        if ({busy, cmd_valid, cmd_op, cmd_data, rom_idx, present, rd_temp, rd_valid,
             scan_done, crc_err, no_bus} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_in_reset: busy=%b cmd_valid=%b op=%b data=%h present=%b temp=%h",
                     busy, cmd_valid, cmd_op, cmd_data, present, rd_temp);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rd_sel = 1'b1; #1;
        n_tests++;
        if ({busy, cmd_valid, rd_temp, rd_valid, present} !== '0) begin
            n_fail++;
            $display("FAIL reset_after_release: busy=%b cmd_valid=%b temp=%h valid=%b present=%b expected all 0",
                     busy, cmd_valid, rd_temp, rd_valid, present);
        end
        rd_sel = 1'b0;
    endtask

    task automatic test_scan_good();
        bit ok;
        load_good(); bus_pres = 1'b1; dev_pres = 2'b11;
        run_scan(1'b1, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL good_timeout: scan_done never seen, required 1"); end
        n_tests++;
        if (n_done != 1) begin n_fail++; $display("FAIL good_done_count: got %0d expected 1", n_done); end
        n_tests++;
        if (n_crc != 0) begin n_fail++; $display("FAIL good_crc_err: got %0d expected 0", n_crc); end
        n_tests++;
        if (present !== 2'b11) begin n_fail++; $display("FAIL good_present: got %b expected 11", present); end
        rd_sel = 1'b0; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== {1'b1, 16'h0550}) begin
            n_fail++; $display("FAIL good_dev0: got valid=%b temp=%h expected 1/0550", rd_valid, rd_temp);
        end
        rd_sel = 1'b1; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== {1'b1, 16'h0550}) begin
            n_fail++; $display("FAIL good_dev1: got valid=%b temp=%h expected 1/0550", rd_valid, rd_temp);
        end
        n_tests++;
        if (log_op.size() != 43) begin
            n_fail++; $display("FAIL good_cmd_count: got %0d expected 43", log_op.size());
        end
        n_tests++;
        if ({log_op[0], log_op[1], log_data[1], log_op[2], log_data[2]} !==
            {OP_RST, OP_WR, CMD_SKIP_ROM, OP_WR, CMD_CONVERT_T}) begin
            n_fail++; $display("FAIL good_preamble: got %b %b/%h %b/%h expected RST, WR CC, WR 44",
                               log_op[0], log_op[1], log_data[1], log_op[2], log_data[2]);
        end
        n_tests++;
        if (log_cyc[3] - log_cyc[2] != int'(CONV) + 3) begin
            n_fail++; $display("FAIL good_conv_wait: got %0d cycles expected %0d",
                               log_cyc[3] - log_cyc[2], CONV + 3);
        end
        repeat (20) @(negedge clk);
        #2;
        n_tests++;
        if (busy !== 1'b0 || n_done != 1) begin
            n_fail++; $display("FAIL good_no_restart: got busy=%b done=%0d expected 0/1", busy, n_done);
        end
        run = 1'b0;
        @(negedge clk); #2;
    endtask

    task automatic test_crc_err();
        bit ok;
        load_good(); sp[1][8] = 8'h1D;
        run_scan(1'b0, ok);
        n_tests++;
        if (!ok || n_done != 1) begin n_fail++; $display("FAIL crc_done: got %0d expected 1", n_done); end
        n_tests++;
        if (n_crc != 1) begin n_fail++; $display("FAIL crc_pulse_count: got %0d expected 1", n_crc); end
        rd_sel = 1'b1; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== {1'b0, 16'h0550}) begin
            n_fail++; $display("FAIL crc_dev1: got valid=%b temp=%h expected 0/0550", rd_valid, rd_temp);
        end
        rd_sel = 1'b0; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== {1'b1, 16'h0550}) begin
            n_fail++; $display("FAIL crc_dev0: got valid=%b temp=%h expected 1/0550", rd_valid, rd_temp);
        end
        n_tests++;
        if (present !== 2'b11) begin n_fail++; $display("FAIL crc_present: got %b expected 11", present); end
        load_good();
    endtask

    task automatic test_no_bus();
        bit ok;
        bus_pres = 1'b0;
        run_scan(1'b0, ok);
        n_tests++;
        if (!ok || n_done != 1 || n_nobus != 1) begin
            n_fail++; $display("FAIL nobus_pulses: got done=%0d no_bus=%0d expected 1/1", n_done, n_nobus);
        end
        n_tests++;
        if (present !== 2'b00) begin n_fail++; $display("FAIL nobus_present: got %b expected 00", present); end
        rd_sel = 1'b0; #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL nobus_valid0: got %b expected 0", rd_valid); end
        rd_sel = 1'b1; #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL nobus_valid1: got %b expected 0", rd_valid); end
        n_tests++;
        if (log_op.size() != 1) begin
            n_fail++; $display("FAIL nobus_cmd_count: got %0d expected 1", log_op.size());
        end
        bus_pres = 1'b1;
    endtask

    task automatic test_dev0_absent();
        bit ok;
        logic [63:0] seen;
        dev_pres = 2'b10;
        run_scan(1'b0, ok);
        n_tests++;
        if (!ok || present !== 2'b10) begin
            n_fail++; $display("FAIL absent_present: got %b expected 10", present);
        end
        n_tests++;
        if (log_op.size() != 24) begin
            n_fail++; $display("FAIL absent_cmd_count: got %0d expected 24", log_op.size());
        end
        n_tests++;
        if ({log_op[3], log_op[4], log_op[5], log_data[5]} !== {OP_RST, OP_RST, OP_WR, CMD_MATCH_ROM}) begin
            n_fail++; $display("FAIL absent_seq: got %b %b %b/%h expected RST RST WR/55",
                               log_op[3], log_op[4], log_op[5], log_data[5]);
        end
        for (int k = 0; k < 8; k++) seen[k*8 +: 8] = log_data[6+k];
        n_tests++;
        if (seen !== ROM1) begin n_fail++; $display("FAIL absent_rom1: got %h expected %h", seen, ROM1); end
        rd_sel = 1'b0; #1;
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL absent_valid0: got %b expected 0", rd_valid); end
        dev_pres = 2'b11;
    endtask

    task automatic test_stall();
        bit ok;
        logic [63:0] seen;
        stall_armed = 1'b1;
        run_scan(1'b0, ok);
        n_tests++;
        if (!ok || stall_cycles != 5 || stall_bad) begin
            n_fail++; $display("FAIL stall_hold: got cycles=%0d unstable=%b expected 5/0", stall_cycles, stall_bad);
        end
        n_tests++;
        if (log_op.size() != 43) begin
            n_fail++; $display("FAIL stall_cmd_count: got %0d expected 43", log_op.size());
        end
        for (int k = 0; k < 8; k++) seen[k*8 +: 8] = log_data[5+k];
        n_tests++;
        if (seen !== ROM0) begin n_fail++; $display("FAIL stall_rom0: got %h expected %h", seen, ROM0); end
        for (int k = 0; k < 8; k++) seen[k*8 +: 8] = log_data[25+k];
        n_tests++;
        if (seen !== ROM1) begin n_fail++; $display("FAIL stall_rom1: got %h expected %h", seen, ROM1); end
        n_tests++;
        if (present !== 2'b11) begin n_fail++; $display("FAIL stall_present: got %b expected 11", present); end
    endtask

    task automatic test_reset_mid_read();
        bit hit;
        int rsp_before, log_before;
        model_clear();
        run = 1'b1;
        repeat (2) @(negedge clk);
        #2 run = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (rst_cnt == 2 && rd_cnt == 5) begin hit = 1'b1; break; end
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL midrst_reach: read byte 4 never issued, required 1"); end
        rsp_before = n_rsp;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        log_before = log_op.size();
        n_done = 0; n_crc = 0; n_nobus = 0;
        repeat (10) @(negedge clk);
        #2;
        n_tests++;
        if (n_rsp != rsp_before + 1) begin
            n_fail++; $display("FAIL midrst_stray: got %0d responses expected %0d", n_rsp - rsp_before, 1);
        end
        n_tests++;
        if ({busy, cmd_valid, present, n_done != 0, n_crc != 0, n_nobus != 0} !== '0) begin
            n_fail++; $display("FAIL midrst_idle: got busy=%b cmd_valid=%b present=%b pulses=%0d/%0d/%0d expected 0",
                               busy, cmd_valid, present, n_done, n_crc, n_nobus);
        end
        n_tests++;
        if (log_op.size() != log_before) begin
            n_fail++; $display("FAIL midrst_no_cmd: got %0d commands expected %0d", log_op.size(), log_before);
        end
        rd_sel = 1'b0; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== 17'd0) begin
            n_fail++; $display("FAIL midrst_table0: got valid=%b temp=%h expected 0/0000", rd_valid, rd_temp);
        end
        rd_sel = 1'b1; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== 17'd0) begin
            n_fail++; $display("FAIL midrst_table1: got valid=%b temp=%h expected 0/0000", rd_valid, rd_temp);
        end
    endtask

    task automatic test_all_ff();
        bit ok;
        load_good();
        for (int k = 0; k < 9; k++) sp[0][k] = 8'hFF;
        run_scan(1'b0, ok);
        n_tests++;
        if (!ok || n_crc != 1) begin n_fail++; $display("FAIL allff_crc_err: got %0d expected 1", n_crc); end
        rd_sel = 1'b0; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== 17'd0) begin
            n_fail++; $display("FAIL allff_dev0: got valid=%b temp=%h expected 0/0000", rd_valid, rd_temp);
        end
        rd_sel = 1'b1; #1;
        n_tests++;
        if ({rd_valid, rd_temp} !== {1'b1, 16'h0550}) begin
            n_fail++; $display("FAIL allff_dev1: got valid=%b temp=%h expected 1/0550", rd_valid, rd_temp);
        end
        n_tests++;
        if (present !== 2'b11) begin n_fail++; $display("FAIL allff_present: got %b expected 11", present); end
        load_good();
    endtask

    initial begin
        good_sp = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
        rst_n = 1'b0; run = 1'b0; rd_sel = '0;
        bus_pres = 1'b1; dev_pres = 2'b11; stall_armed = 1'b0;
        model_clear();
        load_good();
        test_reset();
        test_scan_good();
        test_crc_err();
        test_no_bus();
        test_dev0_absent();
        test_stall();
        test_reset_mid_read();
        test_all_ff();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
